// File: rtl/bucket_range_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bucket_range_decoder
// Purpose  : Inverse of the 10-bit log2 bucket encoder. Takes a bucket code
//            and produces the range of encoder inputs that map to it, either
//            as one beat carrying the bounds (single mode) or as one beat per
//            preimage value lo..hi (expand mode).
// Ports    : c            - clock, rising edge
//            rst          - synchronous reset, active-high
//            in_valid/in_ready/in_code/in_expand - code input handshake
//            out_valid/out_ready/out_val/out_lo/out_hi/out_last - beat output
//            err_invalid  - sticky flag, an accepted code was > 9
//            err_count    - saturating count of accepted invalid codes
//            trig_hit/trig_count - trigger-pattern monitor outputs
// Options  : TROJAN_MONITOR_EN - when defined, trig_hit/trig_count watch
//            transferred beats for the encoder trigger pattern (low nibble
//            4'b1011); when undefined they are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module bucket_range_decoder #(
  parameter int DW  = 10,
  parameter int CW  = 4,
  parameter int ECW = 8
) (
  input  logic          c,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_code,
  input  logic          in_expand,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_val,
  output logic [DW-1:0] out_lo,
  output logic [DW-1:0] out_hi,
  output logic          out_last,
  output logic          err_invalid,
  output logic [ECW-1:0] err_count,
  output logic          trig_hit,
  output logic [7:0]    trig_count
);

  localparam logic [CW-1:0] c_max_code = CW'(9);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_WALK   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid, w_out_valid_nxt;
  logic [DW-1:0]   r_val, w_val_nxt;
  logic [DW-1:0]   r_lo, w_lo_nxt;
  logic [DW-1:0]   r_hi, w_hi_nxt;
  logic            r_last, w_last_nxt;
  logic            r_err_invalid;
  logic [ECW-1:0]  r_err_count;

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_code_ok;
  logic [DW-1:0]   w_range_lo;
  logic [DW-1:0]   w_range_hi;
  logic [DW:0]     w_wide_lo;
  logic [DW:0]     w_wide_hi;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_code_ok  = (in_code <= c_max_code);

  // Bounds are computed one bit wider than DW so that 2^(k+1) for code 9
  // (1024) is representable before the -1 brings it back into range.
  always_comb begin
    w_wide_lo  = (DW+1)'(1) << in_code;
    w_wide_hi  = ((DW+1)'(1) << (in_code + CW'(1))) - (DW+1)'(1);
    w_range_lo = w_wide_lo[DW-1:0];
    w_range_hi = w_wide_hi[DW-1:0];
    if (in_code == CW'(0)) begin
      w_range_lo = '0;
      w_range_hi = '0;
    end else if (in_code == CW'(1)) begin
      w_range_lo = DW'(1);
      w_range_hi = DW'(3);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_val_nxt       = r_val;
    w_lo_nxt        = r_lo;
    w_hi_nxt        = r_hi;
    w_last_nxt      = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_in_xfer && w_code_ok) begin
          w_out_valid_nxt = 1'b1;
          w_val_nxt       = w_range_lo;
          w_lo_nxt        = w_range_lo;
          w_hi_nxt        = w_range_hi;
          if (in_expand) begin
            w_state_nxt = S_WALK;
            w_last_nxt  = (w_range_lo == w_range_hi);
          end else begin
            w_state_nxt = S_SINGLE;
            w_last_nxt  = 1'b1;
          end
        end
      end
      S_SINGLE: begin
        if (w_out_xfer) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_last_nxt      = 1'b0;
        end
      end
      S_WALK: begin
        if (w_out_xfer) begin
          if (r_val == r_hi) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_last_nxt      = 1'b0;
          end else begin
            w_val_nxt  = r_val + DW'(1);
            w_last_nxt = ((r_val + DW'(1)) == r_hi);
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
        w_last_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_val         <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_last        <= 1'b0;
      r_err_invalid <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Registered from the next state so in_ready never depends on out_ready
      // combinationally, yet still equals (state == IDLE) every cycle.
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= w_out_valid_nxt;
      r_val       <= w_val_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_last      <= w_last_nxt;
      if (w_in_xfer && !w_code_ok) begin
        r_err_invalid <= 1'b1;
        if (r_err_count != {ECW{1'b1}}) begin
          r_err_count <= r_err_count + ECW'(1);
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_val     = r_val;
  assign out_lo      = r_lo;
  assign out_hi      = r_hi;
  assign out_last    = r_last;
  assign err_invalid = r_err_invalid;
  assign err_count   = r_err_count;

`ifdef TROJAN_MONITOR_EN
  logic       r_trig_hit;
  logic [7:0] r_trig_count;
  logic       w_trig_match;

  assign w_trig_match = w_out_xfer && (r_val[3:0] == 4'b1011);

  always_ff @(posedge c) begin
    if (rst) begin
      r_trig_hit   <= 1'b0;
      r_trig_count <= '0;
    end else begin
      r_trig_hit <= w_trig_match;
      if (w_trig_match && r_trig_count != 8'hFF) begin
        r_trig_count <= r_trig_count + 8'd1;
      end
    end
  end

  assign trig_hit   = r_trig_hit;
  assign trig_count = r_trig_count;
`else
  assign trig_hit   = 1'b0;
  assign trig_count = 8'd0;
`endif

endmodule
`default_nettype wire
